// File: rtl/drop_sequencer.sv
// Debounced, timed and interlocked hatch-actuation sequencer driven by the drop verdict.
// Define DROP_COUNT_EN to build the saturating drop_count register; otherwise drop_count is tied to 0.
module drop_sequencer #(
   parameter int CONFIRM_CYCLES  = 4,
   parameter int OPEN_MIN        = 8,
   parameter int COOLDOWN_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        drop_activated,
   input  logic        drop_en,
   input  logic [15:0] t_act,
   output logic        hatch_open,
   output logic        busy,
   output logic        done,
   output logic        aborted,
   output logic [7:0]  drop_count
);

   typedef enum logic [1:0] {IDLE, ARM, OPEN, COOLDOWN} state_t;

   localparam logic [7:0]  CONFIRM_TGT = 8'(CONFIRM_CYCLES);
   localparam logic [15:0] OPEN_MIN_W  = 16'(OPEN_MIN);
   localparam logic [15:0] COOL_LOAD   = 16'(COOLDOWN_CYCLES - 1);

   state_t      state;
   logic [7:0]  confirm_cnt;
   logic [15:0] open_cnt;
   logic [15:0] cool_cnt;
   logic        released;
   logic        qualify;
   logic        close_normal;
   logic [15:0] open_len;

   // Valid/ready-free interface: qualify is a level sampled on every rising edge, no handshake.
   assign qualify      = drop_en & drop_activated;
   assign close_normal = (state == OPEN) & drop_en & (open_cnt == 16'd0);
   assign open_len     = (t_act > OPEN_MIN_W) ? t_act : OPEN_MIN_W;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         confirm_cnt <= 8'd0;
         open_cnt    <= 16'd0;
         cool_cnt    <= 16'd0;
         released    <= 1'b1;
         hatch_open  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         if (!drop_activated)
            released <= 1'b1;
         case (state)
            IDLE: begin
               if (qualify && released) begin
                  busy        <= 1'b1;
                  confirm_cnt <= 8'd1;
                  if (CONFIRM_CYCLES == 1) begin
                     // open_cnt captures the fall time, so later t_act changes are ignored
                     state      <= OPEN;
                     open_cnt   <= open_len - 16'd1;
                     hatch_open <= 1'b1;
                     released   <= 1'b0;
                  end else begin
                     state <= ARM;
                  end
               end
            end
            ARM: begin
               if (qualify) begin
                  confirm_cnt <= confirm_cnt + 8'd1;
                  if (confirm_cnt + 8'd1 == CONFIRM_TGT) begin
                     state      <= OPEN;
                     open_cnt   <= open_len - 16'd1;
                     hatch_open <= 1'b1;
                     released   <= 1'b0;
                  end
               end else begin
                  state       <= IDLE;
                  confirm_cnt <= 8'd0;
                  busy        <= 1'b0;
               end
            end
            OPEN: begin
               if (!drop_en) begin
                  hatch_open <= 1'b0;
                  aborted    <= 1'b1;
                  state      <= COOLDOWN;
                  cool_cnt   <= COOL_LOAD;
               end else if (close_normal) begin
                  hatch_open <= 1'b0;
                  done       <= 1'b1;
                  state      <= COOLDOWN;
                  cool_cnt   <= COOL_LOAD;
               end else begin
                  open_cnt <= open_cnt - 16'd1;
               end
            end
            COOLDOWN: begin
               if (cool_cnt == 16'd0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cool_cnt <= cool_cnt - 16'd1;
               end
            end
            default: begin
               state      <= IDLE;
               busy       <= 1'b0;
               hatch_open <= 1'b0;
            end
         endcase
      end
   end

`ifdef DROP_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         drop_count <= 8'd0;
      else if (close_normal && drop_count != 8'hFF)
         drop_count <= drop_count + 8'd1;
   end
`else
   assign drop_count = 8'd0;
`endif

endmodule

// File: doc/drop_sequencer.md
Name: drop_sequencer

Overview:
- Downstream of the drop decision logic. Consumes its `drop_activated` verdict plus the computed fall time `t_act`.
- Turns the one-cycle-sampled, combinational verdict into a debounced, timed, interlocked hatch-actuation sequence.
- Drives the physical hatch, status flags and an optional drop counter.

Parameters:
- CONFIRM_CYCLES, 4, consecutive qualifying clock edges required before opening (>=1).
- OPEN_MIN, 8, minimum hatch-open duration in cycles (>=1, <=65535).
- COOLDOWN_CYCLES, 16, closed dwell after every open before a new drop may arm (>=1, <=65535).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- drop_activated  in  1  drop verdict from the display/drop stage.
- drop_en  in  1  operator drop enable.
- t_act  in  16  computed fall time; used as hatch-open duration in cycles.
- hatch_open  out  1  actuator drive; 1 = hatch open.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse on normal hatch close.
- aborted  out  1  one-cycle pulse when an open is cut short by drop_en falling.
- drop_count  out  8  saturating count of completed (non-aborted) drops.

Behaviour:
- All outputs registered. Reset values:
  - hatch_open=0, busy=0, done=0, aborted=0, drop_count=0.
  - state=IDLE, all counters=0, released=1.
- rst has priority over everything. Asserting it mid-sequence closes the hatch at the next edge; done and aborted are not pulsed.
- qualify = drop_en & drop_activated, sampled each rising edge.
- released flag: cleared on entry to OPEN; set on any edge where drop_activated=0. It prevents a held verdict from re-triggering after cooldown.
- States: IDLE, ARM, OPEN, COOLDOWN.
- IDLE:
  - If qualify & released: confirm_cnt<=1.
  - If CONFIRM_CYCLES==1, go straight to OPEN; otherwise go to ARM.
- ARM:
  - If qualify: confirm_cnt increments. When the incremented value equals CONFIRM_CYCLES, go to OPEN.
  - If qualify=0 on any edge: go to IDLE and clear confirm_cnt. No partial credit.
- Entry to OPEN, on the same edge:
  - t_lat <= t_act.
  - open_cnt <= max(t_act, OPEN_MIN) - 1.
  - hatch_open <= 1.
- OPEN:
  - If drop_en=0: hatch_open<=0, aborted<=1 for one cycle, go to COOLDOWN. drop_count is unchanged.
  - Else if open_cnt==0: hatch_open<=0, done<=1 for one cycle, drop_count increments (saturates at 255), go to COOLDOWN.
  - Else open_cnt decrements.
  - Hatch is therefore high for exactly max(t_act,OPEN_MIN) cycles when not aborted.
- drop_activated falling during OPEN does not close the hatch; only drop_en or timeout does.
- t_act changes after latch are ignored. t_act=0 gives OPEN_MIN cycles.
- COOLDOWN:
  - cool_cnt is loaded with COOLDOWN_CYCLES-1 on entry and decrements each edge.
  - At 0, go to IDLE. Duration is exactly COOLDOWN_CYCLES cycles; inputs are ignored.
- Latency: hatch_open rises on the CONFIRM_CYCLES-th consecutive qualifying edge.
- Width rules: open_cnt and cool_cnt are 16 bits; confirm_cnt is 8 bits. Compare max(t_act,OPEN_MIN) unsigned, at 16 bits.
- done and aborted are never high together. Both are 0 outside their single pulse cycle.

Optional Feature:
DROP_COUNT_EN
- Defined: the 8-bit saturating drop_count register exists and behaves as above.
- Undefined: no counter register; drop_count is tied to 0. All other behaviour is identical.

Test Plan:
- Debounce:
  - Stimulus: defaults, drop_en=1, drop_activated=1 from edge 0, t_act=20.
  - Required: hatch_open=1 after edge 3 for exactly 20 cycles; done pulses on the close edge; busy stays high 20+16 cycles after ARM/OPEN; drop_count=1 (macro on).
- Glitch reject:
  - Stimulus: drop_activated high 3 edges, low 1 edge, then high 4 edges.
  - Required: no open after the first 3 edges; hatch opens only after the 4th edge of the second run.
- Minimum time:
  - Stimulus: t_act=0, then separately t_act=5.
  - Required: hatch open exactly 8 cycles in both cases.
- Abort:
  - Stimulus: t_act=100; drop_en dropped on the 10th open cycle.
  - Required: hatch closes next edge; aborted pulses once; done=0; drop_count unchanged; 16-cycle cooldown still enforced.
- Interlock and reset:
  - Stimulus: hold drop_activated=1 through cooldown.
  - Required: no second drop until drop_activated goes low and then high for 4 edges.
  - Stimulus: assert rst mid-OPEN.
  - Required: all outputs 0 on the next edge.
- Saturation:
  - Stimulus: 256 complete drops.
  - Required: drop_count holds at 255 with macro on; drop_count=0 throughout with macro off.
